// File: rtl/serial_frame_tx.sv
// Framed parallel-to-serial transmitter: start(0), DATA_W bits LSB first, stop(1).
// Optional even-parity bit between data and stop when TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line idle high, waiting for ld
// START  | start bit (0) on co
// DATA   | data bits on co, LSB first
// PARITY | even parity of the latched word on co (TX_PARITY_EN only)
// STOP   | stop bit (1) on co; ld here chains the next frame
module serial_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic              cen,
    input  logic [DATA_W-1:0] par_ld,
    output logic              co
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  sreg;
    logic [CNT_W-1:0]   cnt;
`ifdef TX_PARITY_EN
    logic               par_bit;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
            co    <= 1'b1;
`ifdef TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if (cen) begin
            case (state)
                // STOP behaves like IDLE for loading, which gives gapless back-to-back frames
                IDLE, STOP: begin
                    if (ld) begin
                        sreg  <= par_ld;
                        cnt   <= '0;
                        co    <= 1'b0;
                        state <= START;
`ifdef TX_PARITY_EN
                        par_bit <= ^par_ld;
`endif
                    end else begin
                        co    <= 1'b1;
                        state <= IDLE;
                    end
                end
                START: begin
                    co    <= sreg[0];
                    sreg  <= sreg >> 1;
                    state <= DATA;
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
`ifdef TX_PARITY_EN
                        co    <= par_bit;
                        state <= PARITY;
`else
                        co    <= 1'b1;
                        state <= STOP;
`endif
                    end else begin
                        co    <= sreg[0];
                        sreg  <= sreg >> 1;
                        cnt   <= cnt + CNT_W'(1);
                    end
                end
`ifdef TX_PARITY_EN
                PARITY: begin
                    co    <= 1'b1;
                    state <= STOP;
                end
`endif
                default: begin
                    co    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: vector table, directed corner sequences and random
// traffic checked against a frame-queue model of the serial line.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ld  = 1'b0;
    logic       cen = 1'b0;
    logic [7:0] par_ld = 8'h00;
    logic       co;

    int passed = 0;
    int total  = 0;

    logic exp_co = 1'b1;
    logic q[$];

    typedef struct {
        logic       rst;
        logic       cen;
        logic       ld;
        logic [7:0] par;
        logic       exp;
    } vec_t;

    vec_t tbl[19];

    serial_frame_tx #(.DATA_W(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .ld     (ld),
        .cen    (cen),
        .par_ld (par_ld),
        .co     (co)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp)
            $display("FAIL %s t=%0t co=%b expected=%b", name, $time, act, exp);
        else
            passed++;
    endtask

    // Reference: the line is a queue of pending frame bits; empty queue means idle high.
    task automatic push_frame(input logic [7:0] w);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(w[i]);
`ifdef TX_PARITY_EN
        q.push_back(^w);
`endif
        q.push_back(1'b1);
    endtask

    task automatic step(input logic r, input logic c, input logic l, input logic [7:0] p,
                        input string name);
        rst = r; cen = c; ld = l; par_ld = p;
        @(posedge clk);
        if (r) begin
            q.delete();
            exp_co = 1'b1;
        end else if (c) begin
            if (q.size() == 0 && l) push_frame(p);
            if (q.size() != 0) exp_co = q.pop_front();
            else exp_co = 1'b1;
        end
        #1;
        check(name, co, exp_co);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 8'h0D, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 8'h0D, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h0D, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h0D, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b1, 8'h0D, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[16] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1};

        #1;
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].cen, tbl[i].ld, tbl[i].par, "table_model");
            check($sformatf("table[%0d]", i), co, tbl[i].exp);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00, "settle");

        // enable gating: bits stretch over the enable spacing
        for (int i = 0; i < 26; i++)
            step(1'b0, (i % 2) == 0, i == 0, 8'h0D, "gated_frame");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h0D, "cen_low_ld");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 8'h00, "settle");

        // loads during a frame are ignored
        step(1'b0, 1'b1, 1'b1, 8'h3C, "ign_start");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 8'hFF, "ign_mid");
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 8'hFF, "ign_tail");
        step(1'b0, 1'b1, 1'b1, 8'h3C, "ign2_start");
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b1, 8'hFF, "ign2_hold");
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0, 8'h00, "ign2_tail");

        // back-to-back frames with ld held high
        for (int i = 0; i < 36; i++) step(1'b0, 1'b1, 1'b1, 8'hA5, "b2b");
        for (int i = 0; i < 14; i++) step(1'b0, 1'b1, 1'b0, 8'h00, "b2b_tail");

        // reset while data bit 4 is on the line
        step(1'b0, 1'b1, 1'b1, 8'h5A, "rst_start");
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00, "rst_data");
        step(1'b1, 1'b0, 1'b0, 8'h00, "rst_abort");
        check("rst_abort_high", co, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h00, "rst_idle");
        step(1'b0, 1'b1, 1'b1, 8'h5A, "rst_restart");
        check("rst_restart_start_bit", co, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 1'b0, 8'h00, "rst_refill");

        // random traffic
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0, 8'($urandom), "random");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
